led_bcm_scanner: RTL and testbench
==================================

// Module: led_bcm_scanner
// PURPOSE
//  Parametrised HUB75 panel scanner: the successor to the 1-bit fixed-64-column scan FSM.
//  Adds binary-coded-modulation (BCM) colour depth and parametrised geometry.
//  Shifting of the next bit-plane overlaps display of the current one.
//  Sits between pixel painters (combinational, 1-cycle registered lookup) and the DDR pin
//  cells; owns row address, plane sequencing and frame counting.
// PARAMETERS
//  COLS        64   columns shifted per plane (>=2)
//  SCAN_ROWS   32   multiplexed row addresses (power of 2)
//  ADDR_W       5   log2(SCAN_ROWS)
//  DEPTH        4   bit-planes per colour channel (1..8)
//  BASE_TICKS   8   display cycles for plane 0; plane p displays BASE_TICKS<<p (>=1)
//  FRAME_W     13   width of frame counter
// PORTS
//  pll_clk    in   1        single clock, all logic rising-edge
//  reset      in   1        asynchronous, active-high
//  enable     in   1        0 = hold panel blanked after current latch
//  req_x      out  clog2(COLS) column requested from painters
//  req_addr   out  ADDR_W   row address requested (top half y=addr, bottom y=addr+SCAN_ROWS)
//  req_plane  out  3        bit-plane requested
//  px_rgb0    in   3        top-half pixel bit for (req_x,req_addr,req_plane), valid 1 cycle after request
//  px_rgb1    in   3        bottom-half pixel bit, same timing
//  led_rgb0   out  3        registered data to panel R0/G0/B0
//  led_rgb1   out  3        registered data to panel R1/G1/B1
//  led_addr   out  ADDR_W   registered row address to panel
//  blank      out  2        DDR pair {fall-half, rise-half} for OE pin, 1=blanked
//  latch      out  2        DDR pair for LAT pin
//  sclk       out  2        DDR pair for CLK pin (2'b10 = one pulse, data stable at rise)
//  frame      out  FRAME_W  completed-frame count
//  frame_start out 1        1-cycle pulse when plane 0 of row 0 is latched
// BEHAVIOUR
//  Reset: led_rgb*=0, led_addr=0, blank=2'b11, latch=2'b00, sclk=2'b00, frame=0, frame_start=0.
//   Counters x/row/plane = 0; state SHIFT; display timer = 0; primed = 0.
//  Sequencing: plane is the inner loop (0..DEPTH-1), row the outer loop (0..SCAN_ROWS-1).
//   Frame increments (wraps at 2^FRAME_W) after the last plane of the last row is latched.
//  SHIFT:
//   - req_x counts 0..COLS-1, one per cycle; painter data captured one cycle later.
//   - Each captured column is driven on led_rgb* with sclk=2'b10 that cycle; exactly COLS pulses per plane.
//   - sclk=2'b00 otherwise; led_rgb* hold their last value outside SHIFT.
//  WAIT: shift complete; remain until display timer == 0 (and enable==1).
//  LATCH (1 cycle): blank=2'b11, latch=2'b11.
//   - led_addr <= row of the just-shifted plane; timer <= BASE_TICKS<<plane; primed <= 1.
//   - Advance plane/row and return to SHIFT next cycle.
//  Display:
//   - blank=2'b00 while primed and timer>0; timer decrements every cycle, independent of shift state.
//   - When timer reaches 0, blank=2'b11 immediately, even if the next shift is unfinished;
//     illumination therefore equals BASE_TICKS<<p cycles exactly.
//   - Before the first latch after reset, blank stays 2'b11.
//  Address changes only in LATCH, while blank=2'b11.
//  Simultaneous: shift-complete in the same cycle the timer hits 0 -> LATCH next cycle, no extra gap.
//  enable=0: sequencing stalls in WAIT; the running display completes, then blank stays 2'b11.
//   Resumes with LATCH when enable returns to 1.
//  Reset mid-operation: all state returns to reset values within the same cycle (async); no partial latch pulse.
//  req_* change only in SHIFT; painters are required to be pure functions of req_* plus frame.
// TESTING (bench params COLS=4 SCAN_ROWS=2 DEPTH=2 BASE_TICKS=8)
//  Release reset -> blank=11 and no latch until 4 sclk pulses complete.
//   Then 1 latch cycle with led_addr=0, frame_start=1.
//  Plane 0 latched -> blank=00 for exactly 8 cycles; plane 1 -> exactly 16 cycles; count per row.
//  Painter returning x-dependent rgb0=x[2:0] -> led_rgb0 sequence 0,1,2,3 aligned with 4 sclk=10 cycles.
//  4 latches (2 rows x 2 planes) -> frame 0->1.
//   Led_addr sequence 0,0,1,1, changing only while blank=11.
//  BASE_TICKS=1, COLS=64 -> plane 0 lit exactly 1 cycle, blank=11 until the 64-pulse shift ends.
//  Drop enable mid-display -> display finishes, blank held 11, no latch.
//   Re-enable -> latch on next cycle. Assert reset mid-shift -> all outputs at reset values immediately.

Source files
------------

// File: rtl/led_bcm_scanner_if.sv
// Signal bundle between the BCM scanner, its pixel painters and the panel pin cells.
// The scanner drives requests and panel pins; painters answer with pixel bits.
interface led_bcm_scanner_if #(
    parameter int COLS    = 64,
    parameter int ADDR_W  = 5,
    parameter int FRAME_W = 13
) ();
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;

    logic               enable;
    logic [XW-1:0]      req_x;
    logic [ADDR_W-1:0]  req_addr;
    logic [2:0]         req_plane;
    logic [2:0]         px_rgb0;
    logic [2:0]         px_rgb1;
    logic [2:0]         led_rgb0;
    logic [2:0]         led_rgb1;
    logic [ADDR_W-1:0]  led_addr;
    logic [1:0]         blank;
    logic [1:0]         latch;
    logic [1:0]         sclk;
    logic [FRAME_W-1:0] frame;
    logic               frame_start;

    modport master (
        input  enable, px_rgb0, px_rgb1,
        output req_x, req_addr, req_plane, led_rgb0, led_rgb1, led_addr,
               blank, latch, sclk, frame, frame_start
    );

    modport slave (
        output enable, px_rgb0, px_rgb1,
        input  req_x, req_addr, req_plane, led_rgb0, led_rgb1, led_addr,
               blank, latch, sclk, frame, frame_start
    );
endinterface

// File: rtl/led_bcm_scanner.sv
// HUB75 scanner with binary-coded modulation: shifts the next bit-plane while the
// current one is lit, then latches it once the display timer has expired.
module led_bcm_scanner #(
    parameter int COLS       = 64,
    parameter int SCAN_ROWS  = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int BASE_TICKS = 8,
    parameter int FRAME_W    = 13
) (
    input  logic           pll_clk,
    input  logic           reset,
    led_bcm_scanner_if.master bus
);
    localparam int XW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MAX_TICKS = BASE_TICKS << (DEPTH - 1);
    localparam int TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {SHIFT, WAIT, LATCH} state_t;

    state_t             state_reg, state_next;
    logic [XW-1:0]      x_reg;
    logic               issued_reg;
    logic               cap_reg;
    logic               cap_last_reg;
    logic               last_pulse_reg;
    logic [ADDR_W-1:0]  row_reg;
    logic [2:0]         plane_reg;
    logic [TW-1:0]      timer_reg;
    logic               primed_reg;
    logic [2:0]         rgb0_reg;
    logic [2:0]         rgb1_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [1:0]         sclk_reg;
    logic [FRAME_W-1:0] frame_reg;

    logic last_plane;
    logic last_row;
    logic go;

    assign last_plane = (plane_reg == 3'(DEPTH - 1));
    assign last_row   = (row_reg == ADDR_W'(SCAN_ROWS - 1));
    assign go         = (timer_reg == '0) && bus.enable;

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) state_reg <= SHIFT;
        else       state_reg <= state_next;
    end

    // Shift is complete in the cycle its last sclk pulse is on the pins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SHIFT:   if (last_pulse_reg) state_next = go ? LATCH : WAIT;
            WAIT:    if (go) state_next = LATCH;
            LATCH:   state_next = SHIFT;
            default: state_next = SHIFT;
        endcase
    end

    always_comb begin
        bus.latch       = 2'b00;
        bus.frame_start = 1'b0;
        bus.blank       = 2'b11;
        if (state_reg == LATCH) begin
            bus.latch       = 2'b11;
            bus.frame_start = (row_reg == '0) && (plane_reg == 3'd0);
        end else if (primed_reg && (timer_reg != '0)) begin
            bus.blank = 2'b00;
        end
    end

    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            x_reg          <= '0;
            issued_reg     <= 1'b0;
            cap_reg        <= 1'b0;
            cap_last_reg   <= 1'b0;
            last_pulse_reg <= 1'b0;
            row_reg        <= '0;
            plane_reg      <= 3'd0;
            timer_reg      <= '0;
            primed_reg     <= 1'b0;
            rgb0_reg       <= 3'd0;
            rgb1_reg       <= 3'd0;
            addr_reg       <= '0;
            sclk_reg       <= 2'b00;
            frame_reg      <= '0;
        end else begin
            cap_reg      <= 1'b0;
            cap_last_reg <= 1'b0;
            if ((state_reg == SHIFT) && !issued_reg) begin
                cap_reg      <= 1'b1;
                cap_last_reg <= (x_reg == XW'(COLS - 1));
                if (x_reg == XW'(COLS - 1)) issued_reg <= 1'b1;
                else                        x_reg      <= x_reg + 1'b1;
            end

            // Painter answers one cycle after the request; present it with one pulse.
            if (cap_reg) begin
                rgb0_reg <= bus.px_rgb0;
                rgb1_reg <= bus.px_rgb1;
                sclk_reg <= 2'b10;
            end else begin
                sclk_reg <= 2'b00;
            end
            last_pulse_reg <= cap_reg && cap_last_reg;

            if (state_reg == LATCH)     timer_reg <= TW'(BASE_TICKS) << plane_reg;
            else if (timer_reg != '0)   timer_reg <= timer_reg - 1'b1;

            // Address moves into the latch cycle itself so it only ever changes while blanked.
            if (state_next == LATCH) addr_reg <= row_reg;

            if (state_reg == LATCH) begin
                primed_reg <= 1'b1;
                x_reg      <= '0;
                issued_reg <= 1'b0;
                if (last_plane) begin
                    plane_reg <= 3'd0;
                    row_reg   <= last_row ? '0 : row_reg + 1'b1;
                    if (last_row) frame_reg <= frame_reg + 1'b1;
                end else begin
                    plane_reg <= plane_reg + 1'b1;
                end
            end
        end
    end

    assign bus.req_x     = x_reg;
    assign bus.req_addr  = row_reg;
    assign bus.req_plane = plane_reg;
    assign bus.led_rgb0  = rgb0_reg;
    assign bus.led_rgb1  = rgb1_reg;
    assign bus.led_addr  = addr_reg;
    assign bus.sclk      = sclk_reg;
    assign bus.frame     = frame_reg;
endmodule

// File: tb/tb_led_bcm_scanner.sv
// Scoreboard bench for led_bcm_scanner: a frame-order model queues expected columns
// and latch events; a negedge monitor pops and compares them as the DUT produces them.
module tb_led_bcm_scanner;
    localparam int COLS = 4, SR = 2, AW = 1, DEPTH = 2, BASE = 8, FW = 13;
    localparam int N_FRAMES = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_bcm_scanner_if #(.COLS(COLS), .ADDR_W(AW), .FRAME_W(FW)) sif ();
    led_bcm_scanner_if #(.COLS(64), .ADDR_W(AW), .FRAME_W(FW))   sif2 ();

    led_bcm_scanner #(.COLS(COLS), .SCAN_ROWS(SR), .ADDR_W(AW), .DEPTH(DEPTH),
                      .BASE_TICKS(BASE), .FRAME_W(FW))
        dut (.pll_clk(clk), .reset(reset), .bus(sif));

    led_bcm_scanner #(.COLS(64), .SCAN_ROWS(SR), .ADDR_W(AW), .DEPTH(DEPTH),
                      .BASE_TICKS(1), .FRAME_W(FW))
        dut2 (.pll_clk(clk), .reset(reset), .bus(sif2));

    assign sif2.px_rgb0 = 3'd5;
    assign sif2.px_rgb1 = 3'd2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Painter content: frame 0 is an x ramp on rgb0, later frames come from random tables.
    logic [2:0] tbl0 [64];
    logic [2:0] tbl1 [64];

    function automatic logic [2:0] pix0(input int f, input int r, input int p, input int x);
        if (f == 0) return x[2:0];
        return tbl0[(((f % 4) * SR + r) * DEPTH + p) * COLS + x];
    endfunction

    function automatic logic [2:0] pix1(input int f, input int r, input int p, input int x);
        return tbl1[(((f % 4) * SR + r) * DEPTH + p) * COLS + x];
    endfunction

    always @(posedge clk) begin
        sif.px_rgb0 <= pix0(int'(sif.frame), int'(sif.req_addr), int'(sif.req_plane), int'(sif.req_x));
        sif.px_rgb1 <= pix1(int'(sif.frame), int'(sif.req_addr), int'(sif.req_plane), int'(sif.req_x));
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic        fstart;
        logic [15:0] ticks;
        logic [15:0] frame;
    } latch_t;

    logic [5:0] col_q [$];
    latch_t     latch_q [$];

    // Monitor state
    logic       mon_on = 1'b0;
    int         latches_seen = 0;
    int         pulses = 0;
    int         lit = 0;
    int         prev_ticks = 0;
    logic [AW-1:0] prev_addr = '0;
    latch_t     l;
    logic [5:0] c;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sif.blank != 2'b00 && sif.blank != 2'b11) chk("blank_code", int'(sif.blank), 3);
            if (sif.sclk == 2'b10) begin
                if (col_q.size() == 0) begin
                    chk("col_queue_empty", 1, 0);
                end else begin
                    c = col_q.pop_front();
                    chk("column_rgb", int'({sif.led_rgb0, sif.led_rgb1}), int'(c));
                end
                pulses++;
            end
            if (sif.blank == 2'b00) lit++;
            if (sif.led_addr != prev_addr) chk("addr_change_blanked", int'(sif.blank), 3);
            prev_addr = sif.led_addr;
            if (sif.latch == 2'b11) begin
                if (latch_q.size() == 0) begin
                    chk("latch_queue_empty", 1, 0);
                end else begin
                    l = latch_q.pop_front();
                    chk("latch_addr", int'(sif.led_addr), int'(l.addr));
                    chk("frame_start", int'(sif.frame_start), int'(l.fstart));
                    chk("frame_count", int'(sif.frame), int'(l.frame));
                    chk("blank_in_latch", int'(sif.blank), 3);
                    chk("pulses_per_plane", pulses, COLS);
                    chk("lit_cycles_prev", lit, prev_ticks);
                    $display("latch %0d: addr=%0d frame=%0d fstart=%0d pulses=%0d lit_prev=%0d",
                             latches_seen, sif.led_addr, sif.frame, sif.frame_start, pulses, lit);
                    prev_ticks = int'(l.ticks);
                end
                pulses = 0;
                lit = 0;
                latches_seen++;
            end else if (sif.latch != 2'b00) begin
                chk("latch_code", int'(sif.latch), 0);
            end else if (sif.frame_start) begin
                chk("frame_start_outside_latch", 1, 0);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_led_rgb0"}, int'(sif.led_rgb0), 0);
        chk({tag, "_led_rgb1"}, int'(sif.led_rgb1), 0);
        chk({tag, "_led_addr"}, int'(sif.led_addr), 0);
        chk({tag, "_blank"}, int'(sif.blank), 3);
        chk({tag, "_latch"}, int'(sif.latch), 0);
        chk({tag, "_sclk"}, int'(sif.sclk), 0);
        chk({tag, "_frame"}, int'(sif.frame), 0);
        chk({tag, "_frame_start"}, int'(sif.frame_start), 0);
        chk({tag, "_req_x"}, int'(sif.req_x), 0);
    endtask

    // Short-plane, wide-panel instance: plane 0 lit one cycle, then dark until the next 64-pulse shift ends.
    logic dut2_done = 1'b0;
    initial begin : dut2_chk
        int t, p2, lit2, first_blank;
        @(negedge reset);
        t = 0; p2 = 0; lit2 = 0;
        do begin
            @(negedge clk); t++;
            if (sif2.sclk == 2'b10) p2++;
            if (sif2.blank == 2'b00) lit2++;
        end while (sif2.latch != 2'b11 && t < 400);
        chk("d2_first_latch", int'(sif2.latch), 3);
        chk("d2_pulses_first", p2, 64);
        chk("d2_dark_before_latch", lit2, 0);
        t = 0; p2 = 0; lit2 = 0; first_blank = 3;
        do begin
            @(negedge clk); t++;
            if (t == 1) first_blank = int'(sif2.blank);
            if (sif2.sclk == 2'b10) p2++;
            if (sif2.blank == 2'b00) lit2++;
        end while (sif2.latch != 2'b11 && t < 400);
        chk("d2_second_latch", int'(sif2.latch), 3);
        chk("d2_lit_right_after_latch", first_blank, 0);
        chk("d2_plane0_lit_cycles", lit2, 1);
        chk("d2_pulses_second", p2, 64);
        $display("dut2: plane0 lit=%0d cycles, pulses=%0d", lit2, p2);
        dut2_done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int l0, frame_before, i;
        for (int k = 0; k < 64; k++) begin
            tbl0[k] = 3'($urandom_range(0, 7));
            tbl1[k] = 3'($urandom_range(0, 7));
        end
        for (int f = 0; f < N_FRAMES; f++)
            for (int r = 0; r < SR; r++)
                for (int p = 0; p < DEPTH; p++) begin
                    for (int x = 0; x < COLS; x++)
                        col_q.push_back({pix0(f, r, p, x), pix1(f, r, p, x)});
                    latch_q.push_back('{addr: 8'(r), fstart: (r == 0 && p == 0),
                                        ticks: 16'(BASE << p), frame: 16'(f)});
                end

        reset = 1'b1;
        sif.enable = 1'b1;
        sif2.enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;
        mon_on = 1'b1;

        for (i = 0; i < 2000 && latches_seen < 6; i++) @(posedge clk);
        chk("reach_6_latches", int'(latches_seen >= 6), 1);

        // Drop enable mid-display: display completes, no further latch.
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sif.blank == 2'b00) break;
        end
        chk("display_active_before_disable", int'(sif.blank), 0);
        sif.enable = 1'b0;
        l0 = latches_seen;
        repeat (40) @(negedge clk);
        chk("no_latch_while_disabled", latches_seen - l0, 0);
        chk("blank_held_disabled", int'(sif.blank), 3);
        sif.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("latch_after_reenable", int'(sif.latch), 3);

        for (i = 0; i < 3000 && latches_seen < 14; i++) @(posedge clk);
        chk("reach_14_latches", int'(latches_seen >= 14), 1);
        for (i = 0; i < 3000 && !dut2_done; i++) @(posedge clk);
        chk("dut2_finished", int'(dut2_done), 1);

        // Asynchronous reset in the middle of a shift.
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sif.sclk == 2'b10) break;
        end
        chk("mid_shift_found", int'(sif.sclk), 2);
        frame_before = int'(sif.frame);
        chk("frame_advanced", int'(frame_before >= 3), 1);
        mon_on = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset("async_reset");
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
